// File: rtl/qpu_lsu_icb_arb_pkg.sv
// Shared widths, arbiter constants and types for the LSU / measurement-writer
// ICB command arbiter.
package qpu_lsu_icb_arb_pkg;

  localparam int QPU_ADDR_SIZE = 32;
  localparam int QPU_XLEN      = 32;
  localparam int QPU_MAX_BURST = 4;

  localparam logic SRC_M0 = 1'b0;
  localparam logic SRC_M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [QPU_ADDR_SIZE-1:0] addr;
    logic                     read;
    logic [QPU_XLEN-1:0]      wdata;
    logic [QPU_XLEN/8-1:0]    wmask;
    logic                     src;
  } icb_cmd_t;

endpackage

// File: rtl/qpu_lsu_icb_arb_cmd_fifo.sv
// Two-entry command buffer between the arbiter and the data-memory port.
// Head is presented combinationally; an empty buffer drives an all-zero head.
module qpu_lsu_icb_arb_cmd_fifo
  import qpu_lsu_icb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  icb_cmd_t push_cmd,
  output logic     full,
  input  logic     out_ready,
  output logic     out_valid,
  output icb_cmd_t out_cmd
);

  icb_cmd_t   mem [0:FIFO_DEPTH-1];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       pop;

  assign out_valid = (count_reg != 2'd0);
  assign full      = (count_reg == 2'd2);
  assign pop       = out_valid & out_ready;
  assign out_cmd   = out_valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/qpu_lsu_icb_arb.sv
// Arbitrates the LSU (m0) and measurement writer (m1) onto one data-memory ICB
// command channel with bounded bursts and a two-entry output buffer.
module qpu_lsu_icb_arb
  import qpu_lsu_icb_arb_pkg::*;
#(
  parameter int MAX_BURST  = QPU_MAX_BURST,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m0_icb_cmd_valid,
  output logic                     m0_icb_cmd_ready,
  input  logic [QPU_ADDR_SIZE-1:0] m0_icb_cmd_addr,
  input  logic                     m0_icb_cmd_read,
  input  logic [QPU_XLEN-1:0]      m0_icb_cmd_wdata,
  input  logic [QPU_XLEN/8-1:0]    m0_icb_cmd_wmask,
  input  logic                     m1_icb_cmd_valid,
  output logic                     m1_icb_cmd_ready,
  input  logic [QPU_ADDR_SIZE-1:0] m1_icb_cmd_addr,
  input  logic                     m1_icb_cmd_read,
  input  logic [QPU_XLEN-1:0]      m1_icb_cmd_wdata,
  input  logic [QPU_XLEN/8-1:0]    m1_icb_cmd_wmask,
  output logic                     s_icb_cmd_valid,
  input  logic                     s_icb_cmd_ready,
  output logic [QPU_ADDR_SIZE-1:0] s_icb_cmd_addr,
  output logic                     s_icb_cmd_read,
  output logic [QPU_XLEN-1:0]      s_icb_cmd_wdata,
  output logic [QPU_XLEN/8-1:0]    s_icb_cmd_wmask,
  output logic                     s_icb_cmd_src
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  arb_state_e state_reg, state_next;
  logic [3:0] burst_cnt_reg, burst_cnt_next;
  logic       last_srv_reg, last_srv_next;
  logic       gnt_vld, gnt_id;
  logic       fifo_full, accept;
  icb_cmd_t   in_cmd, head_cmd;

  // Grant is purely a function of state and valids; it is only ever given to a valid requester.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = SRC_M0;
    case (state_reg)
      ST_OWN0: begin
        if (m0_icb_cmd_valid && (burst_cnt_reg < MAX_BURST_C || !m1_icb_cmd_valid)) begin
          gnt_vld = 1'b1;
          gnt_id  = SRC_M0;
        end else if (m1_icb_cmd_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = SRC_M1;
        end
      end
      ST_OWN1: begin
        if (m1_icb_cmd_valid && (burst_cnt_reg < MAX_BURST_C || !m0_icb_cmd_valid)) begin
          gnt_vld = 1'b1;
          gnt_id  = SRC_M1;
        end else if (m0_icb_cmd_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = SRC_M0;
        end
      end
      default: begin
        if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = ~last_srv_reg;
        end else if (m0_icb_cmd_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = SRC_M0;
        end else if (m1_icb_cmd_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = SRC_M1;
        end
      end
    endcase
  end

  assign accept           = gnt_vld & ~fifo_full & ~rst;
  assign m0_icb_cmd_ready = accept & (gnt_id == SRC_M0);
  assign m1_icb_cmd_ready = accept & (gnt_id == SRC_M1);

  // A full buffer freezes the FSM, burst counter and last-served marker.
  always_comb begin
    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    last_srv_next  = last_srv_reg;
    if (!fifo_full) begin
      if (accept) begin
        state_next    = (gnt_id == SRC_M1) ? ST_OWN1 : ST_OWN0;
        last_srv_next = gnt_id;
        if (state_reg == state_next) begin
          burst_cnt_next = (burst_cnt_reg == MAX_BURST_C) ? MAX_BURST_C : burst_cnt_reg + 4'd1;
        end else begin
          burst_cnt_next = 4'd1;
        end
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      burst_cnt_reg <= 4'd0;
      last_srv_reg  <= SRC_M1;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
      last_srv_reg  <= last_srv_next;
    end
  end

  always_comb begin
    if (gnt_id == SRC_M1) begin
      in_cmd = '{addr: m1_icb_cmd_addr, read: m1_icb_cmd_read, wdata: m1_icb_cmd_wdata,
                 wmask: m1_icb_cmd_wmask, src: SRC_M1};
    end else begin
      in_cmd = '{addr: m0_icb_cmd_addr, read: m0_icb_cmd_read, wdata: m0_icb_cmd_wdata,
                 wmask: m0_icb_cmd_wmask, src: SRC_M0};
    end
  end

  qpu_lsu_icb_arb_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_cmd (in_cmd),
    .full     (fifo_full),
    .out_ready(s_icb_cmd_ready),
    .out_valid(s_icb_cmd_valid),
    .out_cmd  (head_cmd)
  );

  assign s_icb_cmd_addr  = head_cmd.addr;
  assign s_icb_cmd_read  = head_cmd.read;
  assign s_icb_cmd_wdata = head_cmd.wdata;
  assign s_icb_cmd_wmask = head_cmd.wmask;
  assign s_icb_cmd_src   = head_cmd.src;

endmodule

// File: tb/tb_qpu_lsu_icb_arb.sv
// Directed self-checking bench for qpu_lsu_icb_arb (MAX_BURST = 4).
module tb_qpu_lsu_icb_arb;

  logic        clk;
  logic        rst;
  logic        m0_valid, m0_ready, m0_read;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_wmask;
  logic        m1_valid, m1_ready, m1_read;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_wmask;
  logic        s_valid, s_ready, s_read, s_src;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wmask;

  int checks = 0;
  int errors = 0;

  qpu_lsu_icb_arb dut (
    .clk             (clk),
    .rst             (rst),
    .m0_icb_cmd_valid(m0_valid),
    .m0_icb_cmd_ready(m0_ready),
    .m0_icb_cmd_addr (m0_addr),
    .m0_icb_cmd_read (m0_read),
    .m0_icb_cmd_wdata(m0_wdata),
    .m0_icb_cmd_wmask(m0_wmask),
    .m1_icb_cmd_valid(m1_valid),
    .m1_icb_cmd_ready(m1_ready),
    .m1_icb_cmd_addr (m1_addr),
    .m1_icb_cmd_read (m1_read),
    .m1_icb_cmd_wdata(m1_wdata),
    .m1_icb_cmd_wmask(m1_wmask),
    .s_icb_cmd_valid (s_valid),
    .s_icb_cmd_ready (s_ready),
    .s_icb_cmd_addr  (s_addr),
    .s_icb_cmd_read  (s_read),
    .s_icb_cmd_wdata (s_wdata),
    .s_icb_cmd_wmask (s_wmask),
    .s_icb_cmd_src   (s_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int exp_g2[6] = '{0, 0, 0, 0, 1, 1};
  int exp_g4[4] = '{0, 0, 0, 1};

  initial begin
    rst = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h40; m0_read = 1'b1; m0_wdata = '0; m0_wmask = '0;
    m1_valid = 1'b0; m1_addr = '0;     m1_read = 1'b1; m1_wdata = '0; m1_wmask = '0;
    s_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_m0_ready", m0_ready, 1'b0);
    chk1("rst_m1_ready", m1_ready, 1'b0);
    chk1("rst_s_valid", s_valid, 1'b0);
    chk1("rst_s_src", s_src, 1'b0);
    chk32("rst_s_addr", s_addr, 32'h0);

    // Single m0 read: one-cycle latency to the output.
    rst = 1'b0;
    #1;
    chk1("t1_m0_ready", m0_ready, 1'b1);
    chk1("t1_m1_ready", m1_ready, 1'b0);
    @(negedge clk);
    chk1("t1_s_valid", s_valid, 1'b1);
    chk32("t1_s_addr", s_addr, 32'h40);
    chk1("t1_s_read", s_read, 1'b1);
    chk1("t1_s_src", s_src, 1'b0);
    $display("txn t1: m0 read addr=%h src=%0d", s_addr, s_src);
    m0_valid = 1'b0;
    @(negedge clk);
    chk1("t1_s_drained", s_valid, 1'b0);

    // Contention after reset: 4 m0 grants, then m1 takes over.
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h100;
    m1_valid = 1'b1; m1_addr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk1("t2_m0_ready", m0_ready, exp_g2[i] == 0);
      chk1("t2_m1_ready", m1_ready, exp_g2[i] == 1);
      if (i > 0) begin
        chk1("t2_s_valid", s_valid, 1'b1);
        chk1("t2_s_src", s_src, exp_g2[i-1] == 1);
      end
      $display("txn t2[%0d]: m0_ready=%b m1_ready=%b s_src=%b", i, m0_ready, m1_ready, s_src);
      @(negedge clk);
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Back-pressure: buffer fills after 2 accepts, head held, then in-order drain.
    s_ready = 1'b0; m0_valid = 1'b1; m0_addr = 32'h10;
    #1 chk1("t3_acc0", m0_ready, 1'b1);
    @(negedge clk);
    m0_addr = 32'h14;
    #1 chk1("t3_acc1", m0_ready, 1'b1);
    @(negedge clk);
    m0_addr = 32'h18;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("t3_full_m0_ready", m0_ready, 1'b0);
      chk1("t3_full_m1_ready", m1_ready, 1'b0);
      chk1("t3_full_s_valid", s_valid, 1'b1);
      chk32("t3_head_hold", s_addr, 32'h10);
      $display("txn t3 stall[%0d]: head=%h", i, s_addr);
      @(negedge clk);
    end
    s_ready = 1'b1;
    #1 chk1("t3_ready_indep", m0_ready, 1'b0);
    @(negedge clk);
    chk32("t3_drain1", s_addr, 32'h14);
    chk1("t3_drain1_valid", s_valid, 1'b1);
    #1 chk1("t3_refill", m0_ready, 1'b1);
    @(negedge clk);
    chk32("t3_drain2", s_addr, 32'h18);
    m0_valid = 1'b0;
    @(negedge clk);
    chk1("t3_empty", s_valid, 1'b0);

    // m1 store, then m1 drops at burst 2 and m0 restarts with a fresh burst.
    m1_valid = 1'b1; m1_addr = 32'h80; m1_read = 1'b0;
    m1_wdata = 32'hDEADBEEF; m1_wmask = 4'hF;
    #1;
    chk1("t4_m1_ready", m1_ready, 1'b1);
    chk1("t4_m0_ready", m0_ready, 1'b0);
    @(negedge clk);
    chk1("t4_s_read", s_read, 1'b0);
    chk32("t4_s_wdata", s_wdata, 32'hDEADBEEF);
    chk32("t4_s_wmask", {28'h0, s_wmask}, 32'hF);
    chk1("t4_s_src", s_src, 1'b1);
    chk32("t4_s_addr", s_addr, 32'h80);
    $display("txn t4: m1 store addr=%h wdata=%h wmask=%h", s_addr, s_wdata, s_wmask);
    m1_addr = 32'h84;
    #1 chk1("t4_m1_second", m1_ready, 1'b1);
    @(negedge clk);
    m1_valid = 1'b0; m0_valid = 1'b1; m0_addr = 32'h20;
    #1;
    chk1("t4_switch_m0", m0_ready, 1'b1);
    chk1("t4_switch_m1", m1_ready, 1'b0);
    chk32("t4_s_addr2", s_addr, 32'h84);
    @(negedge clk);
    m1_valid = 1'b1; m1_addr = 32'h88;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("t4_burst_m0", m0_ready, exp_g4[i] == 0);
      chk1("t4_burst_m1", m1_ready, exp_g4[i] == 1);
      $display("txn t4[%0d]: m0_ready=%b m1_ready=%b", i, m0_ready, m1_ready);
      @(negedge clk);
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset with two buffered commands.
    s_ready = 1'b0; m0_valid = 1'b1; m0_addr = 32'h30; m0_read = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk1("t5_full", m0_ready, 1'b0);
    chk1("t5_s_valid", s_valid, 1'b1);
    rst = 1'b1; m1_valid = 1'b1; m1_read = 1'b1;
    #1;
    chk1("t5_rst_m0_ready", m0_ready, 1'b0);
    chk1("t5_rst_m1_ready", m1_ready, 1'b0);
    @(negedge clk);
    chk1("t5_flush_valid", s_valid, 1'b0);
    chk1("t5_flush_src", s_src, 1'b0);
    chk32("t5_flush_addr", s_addr, 32'h0);
    rst = 1'b0; s_ready = 1'b1;
    #1;
    chk1("t5_post_m0", m0_ready, 1'b1);
    chk1("t5_post_m1", m1_ready, 1'b0);
    chk1("t5_post_empty", s_valid, 1'b0);
    @(negedge clk);
    chk1("t5_out_valid", s_valid, 1'b1);
    chk1("t5_out_src", s_src, 1'b0);
    chk32("t5_out_addr", s_addr, 32'h30);
    $display("txn t5: post-reset winner src=%0d addr=%h", s_src, s_addr);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
